// File: rtl/nh_lcd_bus_arbiter_pkg.sv
// Shared encodings, pin payload and idle constants for the LCD bus arbiter.
package nh_lcd_defines;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned STARVE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANT_CMD  = 2'd1,
    ST_GRANT_PIX  = 2'd2,
    ST_TURNAROUND = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_PIX = 1'b0,
    OWNER_CMD = 1'b1
  } owner_e;

  typedef struct packed {
    logic              cmd_mode;
    logic              write;
    logic              read;
    logic              data_out_en;
    logic [DATA_W-1:0] data;
  } lcd_pins_t;

  localparam logic              CMD_MODE_IDLE = 1'b1;
  localparam logic [DATA_W-1:0] DATA_IDLE     = 8'h00;

  localparam lcd_pins_t PINS_IDLE = '{
    cmd_mode:    CMD_MODE_IDLE,
    write:       1'b0,
    read:        1'b0,
    data_out_en: 1'b1,
    data:        DATA_IDLE
  };

  // Tie goes to whichever requester did not own the bus last.
  function automatic arb_state_e arbitrate(input logic cmd_req, input logic pix_req,
                                           input owner_e last_owner);
    if (cmd_req && (!pix_req || last_owner == OWNER_PIX)) begin
      return ST_GRANT_CMD;
    end
    if (pix_req) begin
      return ST_GRANT_PIX;
    end
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/nh_lcd_bus_mux.sv
// Registered 2:1 LCD pin mux; idle-force parks the bus at its idle values.
module nh_lcd_bus_mux
  import nh_lcd_defines::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_idle,
  input  owner_e    i_sel,
  input  lcd_pins_t i_cmd_pins,
  input  lcd_pins_t i_pix_pins,
  output lcd_pins_t o_pins
);

  lcd_pins_t pins_d;
  lcd_pins_t pins_q;

  always_comb begin
    pins_d = PINS_IDLE;
    if (!i_idle) begin
      pins_d = (i_sel == OWNER_CMD) ? i_cmd_pins : i_pix_pins;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pins_q <= PINS_IDLE;
    end else begin
      pins_q <= pins_d;
    end
  end

  assign o_pins = pins_q;

endmodule

// File: rtl/nh_lcd_bus_arbiter.sv
// Arbitrates the shared 8-bit LCD bus between the command engine and pixel writer,
// with idle turnaround between owners and a starvation-driven pixel yield request.
module nh_lcd_bus_arbiter
  import nh_lcd_defines::*;
#(
  parameter int unsigned TURNAROUND    = 2,
  parameter int unsigned YIELD_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_req,
  input  logic              i_cmd_done,
  output logic              o_cmd_gnt,
  input  logic              i_cmd_cmd_mode,
  input  logic              i_cmd_write,
  input  logic              i_cmd_read,
  input  logic              i_cmd_data_out_en,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic [DATA_W-1:0] o_cmd_rd_data,
  output logic              o_cmd_rd_stb,
  input  logic              i_pix_req,
  input  logic              i_pix_done,
  output logic              o_pix_gnt,
  output logic              o_pix_yield,
  input  logic              i_pix_cmd_mode,
  input  logic              i_pix_write,
  input  logic              i_pix_data_out_en,
  input  logic [DATA_W-1:0] i_pix_data,
  output logic              o_cmd_mode,
  output logic              o_write,
  output logic              o_read,
  output logic              o_data_out_en,
  output logic [DATA_W-1:0] o_data_out,
  input  logic [DATA_W-1:0] i_data_in,
  output logic [31:0]       debug
);

  localparam int unsigned TA_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [TA_W-1:0] TA_LAST = TA_W'((TURNAROUND == 0) ? 0 : TURNAROUND - 1);

  arb_state_e          state_d, state_q;
  owner_e              last_d, last_q;
  logic [TA_W-1:0]     ta_d, ta_q;
  logic [STARVE_W-1:0] cnt_d, cnt_q;
  logic                yield_d, yield_q;
  logic                cmd_gnt_d, cmd_gnt_q;
  logic                pix_gnt_d, pix_gnt_q;
  logic                rd_stb_d, rd_stb_q;
  logic [DATA_W-1:0]   rd_data_d, rd_data_q;
  logic                bus_idle_c;
  owner_e              bus_sel_c;
  lcd_pins_t           cmd_pins, pix_pins, pins;

  assign cmd_pins = '{cmd_mode: i_cmd_cmd_mode, write: i_cmd_write, read: i_cmd_read,
                      data_out_en: i_cmd_data_out_en, data: i_cmd_data};
  assign pix_pins = '{cmd_mode: i_pix_cmd_mode, write: i_pix_write, read: 1'b0,
                      data_out_en: i_pix_data_out_en, data: i_pix_data};

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    ta_d      = ta_q;
    cnt_d     = cnt_q;
    yield_d   = 1'b0;
    rd_stb_d  = 1'b0;
    rd_data_d = rd_data_q;

    unique case (state_q)
      ST_IDLE: state_d = arbitrate(i_cmd_req, i_pix_req, last_q);
      ST_GRANT_CMD, ST_GRANT_PIX: begin
        if ((state_q == ST_GRANT_CMD && i_cmd_done) || (state_q == ST_GRANT_PIX && i_pix_done)) begin
          state_d = (TURNAROUND == 0) ? ST_IDLE : ST_TURNAROUND;
          ta_d    = '0;
        end
      end
      ST_TURNAROUND: begin
        if (ta_q == TA_LAST) begin
          state_d = arbitrate(i_cmd_req, i_pix_req, last_q);
        end else begin
          ta_d = ta_q + TA_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_GRANT_CMD) last_d = OWNER_CMD;
    if (state_d == ST_GRANT_PIX) last_d = OWNER_PIX;

    // Starvation only accrues across consecutive pixel-owned cycles.
    if (state_d != ST_GRANT_PIX) begin
      cnt_d = '0;
    end else if (state_q == ST_GRANT_PIX && i_cmd_req && cnt_q != '1) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
    yield_d = (state_q == ST_GRANT_PIX) && (state_d == ST_GRANT_PIX) &&
              (32'(cnt_q) >= 32'(YIELD_TIMEOUT));

    cmd_gnt_d = (state_d == ST_GRANT_CMD);
    pix_gnt_d = (state_d == ST_GRANT_PIX);

    // Pins follow an owner only while it holds the bus across the edge.
    bus_idle_c = !((state_q == state_d) &&
                   (state_q == ST_GRANT_CMD || state_q == ST_GRANT_PIX));
    bus_sel_c  = (state_q == ST_GRANT_PIX) ? OWNER_PIX : OWNER_CMD;

    if (o_read && state_q == ST_GRANT_CMD) begin
      rd_stb_d  = 1'b1;
      rd_data_d = i_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      last_q    <= OWNER_PIX;
      ta_q      <= '0;
      cnt_q     <= '0;
      yield_q   <= 1'b0;
      cmd_gnt_q <= 1'b0;
      pix_gnt_q <= 1'b0;
      rd_stb_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      ta_q      <= ta_d;
      cnt_q     <= cnt_d;
      yield_q   <= yield_d;
      cmd_gnt_q <= cmd_gnt_d;
      pix_gnt_q <= pix_gnt_d;
      rd_stb_q  <= rd_stb_d;
      rd_data_q <= rd_data_d;
    end
  end

  nh_lcd_bus_mux u_bus_mux (
    .clk        (clk),
    .rst        (rst),
    .i_idle     (bus_idle_c),
    .i_sel      (bus_sel_c),
    .i_cmd_pins (cmd_pins),
    .i_pix_pins (pix_pins),
    .o_pins     (pins)
  );

  assign o_cmd_mode    = pins.cmd_mode;
  assign o_write       = pins.write;
  assign o_read        = pins.read;
  assign o_data_out_en = pins.data_out_en;
  assign o_data_out    = pins.data;

  assign o_cmd_gnt     = cmd_gnt_q;
  assign o_pix_gnt     = pix_gnt_q;
  assign o_pix_yield   = yield_q;
  assign o_cmd_rd_stb  = rd_stb_q;
  assign o_cmd_rd_data = rd_data_q;
  assign debug         = {12'd0, cnt_q, yield_q, last_q, state_q};

endmodule
